// File: rtl/select_pkg.sv
// Types shared by the round-robin feeder and the downstream 4-way select stage.
// The select code doubles as the channel index.
package select_pkg;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {CH_U1 = 2'd0, CH_U2 = 2'd1, CH_S1 = 2'd2, CH_S2 = 2'd3} sel_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Successor channel; wraps 3 -> 0 through 2-bit truncation.
  function automatic sel_t next_ch(sel_t c);
    return sel_t'(c + 2'd1);
  endfunction
endpackage

// File: rtl/select_rr_feeder_if.sv
// Four source channels in, one registered (sel, value) pair out.
// The feeder takes the slave side; the source/sink environment takes the master side.
interface select_rr_feeder_if
  import select_pkg::*;
#(
  parameter int U1_W  = 2,
  parameter int U2_W  = 4,
  parameter int S_W   = 4,
  parameter int OUT_W = 5
);
  logic        [U1_W-1:0]   u1_data;
  logic        [U2_W-1:0]   u2_data;
  logic        [S_W-1:0]    s1_data;
  logic        [S_W-1:0]    s2_data;
  logic        [NUM_CH-1:0] in_valid;
  logic        [NUM_CH-1:0] in_ready;
  logic signed [OUT_W-1:0]  out_data;
  sel_t                     out_sel;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  u1_data, u2_data, s1_data, s2_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output u1_data, u2_data, s1_data, s2_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin search: first valid channel at or after ptr_i wins.
module rr_arbiter4
  import select_pkg::*;
(
  input  logic [NUM_CH-1:0] valid_i,
  input  sel_t              ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output sel_t              idx_o,
  output logic              any_o
);
  logic [1:0] c;

  // Walk from the farthest offset down to ptr_i so the closest valid overrides.
  always_comb begin
    gnt_o = '0;
    idx_o = CH_U1;
    any_o = 1'b0;
    c     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = ptr_i + 2'(i);
      if (valid_i[c]) begin
        gnt_o    = '0;
        gnt_o[c] = 1'b1;
        idx_o    = sel_t'(c);
        any_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/select_rr_feeder.sv
// Round-robin feeder: grants one of four channels, extends the winner to a signed
// OUT_W value and holds it with its select code in a one-entry output register.
module select_rr_feeder
  import select_pkg::*;
#(
  parameter int U1_W  = 2,
  parameter int U2_W  = 4,
  parameter int S_W   = 4,
  parameter int OUT_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  select_rr_feeder_if.slave   bus
);
  state_t                  state_q, state_d;
  logic signed [OUT_W-1:0] data_q, data_d, ext;
  sel_t                    sel_q, sel_d, ptr_q, ptr_d, gnt_idx;
  logic [NUM_CH-1:0]       gnt;
  logic                    any, load, xfer;

  logic        [U1_W-1:0]  u1;
  logic        [U2_W-1:0]  u2;
  logic signed [S_W-1:0]   s1, s2;

  assign u1 = bus.u1_data;
  assign u2 = bus.u2_data;
  assign s1 = bus.s1_data;
  assign s2 = bus.s2_data;

  rr_arbiter4 u_arb (
    .valid_i (bus.in_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .any_o   (any)
  );

  // Register can take a new value when empty or when it drains this edge.
  assign load         = (state_q == EMPTY) || bus.out_ready;
  assign xfer         = rst_ni && load && any;
  assign bus.in_ready = (rst_ni && load) ? gnt : '0;

  // Unsigned channels zero-extend, signed channels sign-extend.
  always_comb begin
    ext = '0;
    unique case (gnt_idx)
      CH_U1:   ext = OUT_W'(u1);
      CH_U2:   ext = OUT_W'(u2);
      CH_S1:   ext = OUT_W'(s1);
      default: ext = OUT_W'(s2);
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (xfer) begin
        state_d = FULL;
        data_d  = ext;
        sel_d   = gnt_idx;
        ptr_d   = next_ch(gnt_idx);
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= CH_U1;
      ptr_q   <= CH_U1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_select_rr_feeder.sv
// Randomised and directed bench for select_rr_feeder with a queue-based scoreboard
// fed by a behavioural round-robin model and drained by an output monitor.
module tb_select_rr_feeder;
  import select_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  select_rr_feeder_if bus ();

  select_rr_feeder dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int sel;
    int val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit   m_full = 1'b0;
  int   m_ptr  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ext_m(input int k, input bit [1:0] a, input bit [3:0] b,
                               input bit [3:0] c, input bit [3:0] d);
    case (k)
      0:       return int'(a);
      1:       return int'(b);
      2:       return (c >= 8) ? int'(c) - 16 : int'(c);
      default: return (d >= 8) ? int'(d) - 16 : int'(d);
    endcase
  endfunction

  // One cycle: drive at negedge, then let the model predict grant and output state.
  task automatic step(input bit r, input bit [3:0] v, input bit ordy,
                      input bit [1:0] a, input bit [3:0] b, input bit [3:0] c, input bit [3:0] d);
    bit  load;
    int  k;
    int  exp_rdy;
    @(negedge clk);
    rst_n        = r;
    bus.in_valid = v;
    bus.out_ready = ordy;
    bus.u1_data  = a;
    bus.u2_data  = b;
    bus.s1_data  = c;
    bus.s2_data  = d;
    #1;
    if (!r) begin
      chk("rst_in_ready", int'(bus.in_ready), 0);
      m_full = 1'b0;
      m_ptr  = 0;
      q.delete();
    end else begin
      load = !m_full || ordy;
      k = -1;
      for (int i = 0; i < 4; i++) begin
        if (k < 0 && v[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
      end
      exp_rdy = (load && k >= 0) ? (1 << k) : 0;
      chk("in_ready", int'(bus.in_ready), exp_rdy);
      chk("out_valid", int'(bus.out_valid), int'(m_full));
      if (load) begin
        if (k >= 0) begin
          q.push_back('{sel: k, val: ext_m(k, a, b, c, d)});
          m_ptr  = (k + 1) % 4;
          m_full = 1'b1;
        end else begin
          m_full = 1'b0;
        end
      end
    end
  endtask

  // Output monitor: pops on every handshake and checks hold behaviour under backpressure.
  initial begin
    bit   pv = 1'b0;
    bit   pr = 1'b0;
    int   psel = 0;
    int   pdata = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (pv && !pr) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_sel", int'(bus.out_sel), psel);
        chk("hold_data", int'(bus.out_data), pdata);
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_sel", int'(bus.out_sel), e.sel);
          chk("sb_data", int'(bus.out_data), e.val);
        end
      end
      pv    = rst_n && bus.out_valid;
      pr    = bus.out_ready;
      psel  = int'(bus.out_sel);
      pdata = int'(bus.out_data);
    end
  end

  initial begin
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    bus.u1_data   = '0;
    bus.u2_data   = '0;
    bus.s1_data   = '0;
    bus.s2_data   = '0;

    // Reset with all channels requesting
    step(0, 4'hF, 1, 2'd1, 4'h2, 4'h3, 4'h4);
    step(0, 4'hF, 1, 2'd1, 4'h2, 4'h3, 4'h4);
    step(1, 4'h0, 1, 2'd0, 4'h0, 4'h0, 4'h0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_sel", int'(bus.out_sel), 0);

    // Single ch2 with most-negative value
    step(1, 4'b0100, 1, 2'd3, 4'h7, 4'h8, 4'h1);
    step(1, 4'b0000, 1, 2'd0, 4'h0, 4'h0, 4'h0);
    chk("t2_sel", int'(bus.out_sel), 2);
    chk("t2_data", int'(bus.out_data), -8);

    // All valid, full throughput; ptr starts at 3 here
    for (int i = 0; i < 5; i++) step(1, 4'hF, 1, 2'd3, 4'hF, 4'h9, 4'hE);
    chk("t3_valid", int'(bus.out_valid), 1);

    // Drive until ch1 holds the register, then stall three cycles
    step(1, 4'b0010, 1, 2'd2, 4'hF, 4'h5, 4'h6);
    step(1, 4'hF, 0, 2'd1, 4'hA, 4'h6, 4'h7);
    chk("t4_sel", int'(bus.out_sel), 1);
    chk("t4_data", int'(bus.out_data), 15);
    step(1, 4'hF, 0, 2'd1, 4'hA, 4'h6, 4'h7);
    step(1, 4'hF, 0, 2'd1, 4'hA, 4'h6, 4'h7);
    step(1, 4'hF, 1, 2'd1, 4'hA, 4'h6, 4'h7);
    step(1, 4'h0, 1, 2'd0, 4'h0, 4'h0, 4'h0);

    // Mid-transfer reset then ptr restarts at ch0
    step(1, 4'hF, 0, 2'd2, 4'h3, 4'hC, 4'hD);
    step(0, 4'hF, 1, 2'd2, 4'h3, 4'hC, 4'hD);
    chk("t5_valid_before", int'(bus.out_valid), 1);
    step(1, 4'b1010, 1, 2'd0, 4'h9, 4'h0, 4'hB);
    chk("t5_valid_after", int'(bus.out_valid), 0);
    step(1, 4'b0000, 1, 2'd0, 4'h0, 4'h0, 4'h0);
    chk("t5_sel", int'(bus.out_sel), 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 3; i++) step(1, 4'h0, 1, 2'd0, 4'h0, 4'h0, 4'h0);
    chk("sb_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
